// File: rtl/mem_reg_dma_pkg.sv
// Shared types and default widths for the SRAM <-> register-file block-transfer engine.
package mem_reg_dma_pkg;

  localparam int unsigned ADDR_W_DEF = 11;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned REG_W_DEF  = 32;

  typedef enum logic [1:0] {
    MODE_FILL  = 2'd0,
    MODE_LOAD  = 2'd1,
    MODE_STORE = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mem_reg_dma_ctr.sv
// Transfer index counter with latched bases and wrapping SRAM / register address generators.
module mem_reg_dma_ctr #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_mem_base,
  input  logic [REG_AW-1:0] i_reg_base,
  output logic [REG_AW:0]   o_idx,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [REG_AW-1:0] o_reg_addr,
  output logic [REG_AW-1:0] o_reg_addr_prev
);

  logic [REG_AW:0]   r_idx;
  logic [ADDR_W-1:0] r_mem_base;
  logic [REG_AW-1:0] r_reg_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_mem_base <= '0;
      r_reg_base <= '0;
    end else if (i_load) begin
      r_idx      <= '0;
      r_mem_base <= i_mem_base;
      r_reg_base <= i_reg_base;
    end else if (i_inc) begin
      r_idx      <= r_idx + (REG_AW+1)'(1);
    end
  end

  // Address widths truncate the sums, giving modulo wrap for free.
  assign o_idx           = r_idx;
  assign o_mem_addr      = r_mem_base + ADDR_W'(r_idx);
  assign o_reg_addr      = r_reg_base + r_idx[REG_AW-1:0];
  assign o_reg_addr_prev = r_reg_base + r_idx[REG_AW-1:0] - REG_AW'(1);

endmodule

// File: rtl/mem_reg_dma.sv
// Block-transfer engine: FILL / LOAD / STORE between SRAM and register file.
// Optional XOR checksum of written words when MEM_REG_DMA_CHECKSUM_EN is defined.
module mem_reg_dma
  import mem_reg_dma_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] mem_base,
  input  logic [REG_AW-1:0] reg_base,
  input  logic [REG_AW:0]   len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [REG_W-1:0]  rf_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [REG_W-1:0]  rf_wdata,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [REG_AW:0] LEN_MAX = {1'b1, {REG_AW{1'b0}}};
  localparam logic [REG_AW:0] LEN_ONE = (REG_AW+1)'(1);

  state_e            r_state, w_state_nx;
  mode_e             r_mode;
  logic [REG_AW:0]   r_len;
  logic [REG_AW:0]   w_len;
  logic              w_accept, w_inc, w_last;
  logic [REG_AW:0]   w_idx;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [REG_AW-1:0] w_reg_addr, w_reg_addr_prev;
  logic              w_unused_rf;

  assign w_len       = (len > LEN_MAX) ? LEN_MAX : len;
  assign w_last      = (w_idx == r_len - LEN_ONE);
  assign w_unused_rf = ^rf_rdata;

  mem_reg_dma_ctr #(
    .ADDR_W (ADDR_W),
    .REG_AW (REG_AW)
  ) u_ctr (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_load          (w_accept),
    .i_inc           (w_inc),
    .i_mem_base      (mem_base),
    .i_reg_base      (reg_base),
    .o_idx           (w_idx),
    .o_mem_addr      (w_mem_addr),
    .o_reg_addr      (w_reg_addr),
    .o_reg_addr_prev (w_reg_addr_prev)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_FILL;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_mode <= mode_e'(mode);
        r_len  <= w_len;
      end
    end
  end

  // Outputs decode straight from state, so an async reset drops every strobe at once.
  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_inc      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    rf_raddr   = '0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept   = 1'b1;
          w_state_nx = (w_len == '0 || mode == MODE_RSVD) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy  = 1'b1;
        w_inc = 1'b1;
        case (r_mode)
          MODE_FILL: begin
            mem_addr  = w_mem_addr;
            mem_we    = 1'b1;
            mem_wdata = ~(DATA_W'(w_idx));
          end
          MODE_STORE: begin
            rf_raddr  = w_reg_addr;
            mem_addr  = w_mem_addr;
            mem_we    = 1'b1;
            mem_wdata = rf_rdata[DATA_W-1:0];
          end
          MODE_LOAD: begin
            mem_addr = w_mem_addr;
            if (w_idx != '0) begin
              rf_we    = 1'b1;
              rf_waddr = w_reg_addr_prev;
              rf_wdata = REG_W'(mem_rdata);
            end
          end
          default: ;
        endcase
        if (w_last)
          w_state_nx = (r_mode == MODE_LOAD) ? ST_DRAIN : ST_DONE;
      end
      ST_DRAIN: begin
        busy       = 1'b1;
        rf_we      = 1'b1;
        rf_waddr   = w_reg_addr_prev;
        rf_wdata   = REG_W'(mem_rdata);
        w_state_nx = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        err        = (r_mode == MODE_RSVD);
        w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

`ifdef MEM_REG_DMA_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_checksum <= '0;
    else if (w_accept)
      r_checksum <= '0;
    else if (mem_we)
      r_checksum <= r_checksum ^ mem_wdata;
    else if (rf_we)
      r_checksum <= r_checksum ^ rf_wdata[DATA_W-1:0];
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_reg_dma.sv
// Directed self-checking bench for mem_reg_dma with behavioural SRAM and register-file models.
module tb_mem_reg_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [10:0] mem_base = '0;
  logic [4:0]  reg_base = '0;
  logic [5:0]  len = '0;
  logic        busy, done, err;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] checksum;

  logic [15:0] sram [0:2047];
  logic [31:0] rf   [0:31];
  logic        tb_we = 1'b0;
  logic [10:0] tb_addr = '0;
  logic [15:0] tb_data = '0;

  int n_checks = 0;
  int n_errors = 0;
  int n_mem_wr = 0;
  int n_rf_wr  = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  mem_reg_dma u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .mem_base  (mem_base),
    .reg_base  (reg_base),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .checksum  (checksum)
  );

  always @(posedge clk) begin
    mem_rdata <= sram[mem_addr];
    if (mem_we)     sram[mem_addr] <= mem_wdata;
    else if (tb_we) sram[tb_addr]  <= tb_data;
    if (rf_we) rf[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata = rf[rf_raddr];

  always @(posedge clk) begin
    if (mem_we) n_mem_wr++;
    if (rf_we)  n_rf_wr++;
    if (done && (mem_we || rf_we)) n_bad++;
    if (busy && done) n_bad++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  task automatic xfer(input logic [1:0] m, input int mb, input int rb, input int ln,
                      output int cyc, output logic e);
    mode     = m;
    mem_base = mb[10:0];
    reg_base = rb[4:0];
    len      = ln[5:0];
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    e = err;
    @(posedge clk); #1;
  endtask

  int   cyc, mw0, rw0;
  logic e;

  initial begin
    #12;
    check("rst_busy",  {31'd0, busy},   0);
    check("rst_done",  {31'd0, done},   0);
    check("rst_err",   {31'd0, err},    0);
    check("rst_we",    {30'd0, mem_we, rf_we}, 0);
    check("rst_addr",  {16'd0, mem_addr, rf_raddr}, 0);
    check("rst_wdata", {mem_wdata, 11'd0, rf_waddr}, 0);
    check("rst_rfwd",  rf_wdata, 0);
    check("rst_csum",  {16'd0, checksum}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // FILL 0..31
    mw0 = n_mem_wr;
    xfer(2'd0, 0, 0, 32, cyc, e);
    check("fill_lat",  cyc, 33);
    check("fill_err",  {31'd0, e}, 0);
    check("fill_n",    n_mem_wr - mw0, 32);
    check("fill_m0",   {16'd0, sram[0]},  32'h0000_FFFF);
    check("fill_m31",  {16'd0, sram[31]}, 32'h0000_FFE0);

    // FILL 64..95 then LOAD into regs 0..31
    xfer(2'd0, 64, 0, 32, cyc, e);
    rw0 = n_rf_wr;
    xfer(2'd1, 64, 0, 32, cyc, e);
    check("load_lat",  cyc, 34);
    check("load_n",    n_rf_wr - rw0, 32);
    check("load_r0",   rf[0],  32'h0000_FFFF);
    check("load_r5",   rf[5],  32'h0000_FFFA);
    check("load_r31",  rf[31], 32'h0000_FFE0);

    // STORE regs 16..19 -> SRAM 145..148
    xfer(2'd2, 145, 16, 4, cyc, e);
    check("store_lat", cyc, 5);
    check("store_m145", {16'd0, sram[145]}, 32'h0000_FFEF);
    check("store_m148", {16'd0, sram[148]}, 32'h0000_FFEC);

    // address wrap
    xfer(2'd0, 2046, 0, 4, cyc, e);
    check("wrapf_2046", {16'd0, sram[2046]}, 32'h0000_FFFF);
    check("wrapf_2047", {16'd0, sram[2047]}, 32'h0000_FFFE);
    check("wrapf_0",    {16'd0, sram[0]},    32'h0000_FFFD);
    check("wrapf_1",    {16'd0, sram[1]},    32'h0000_FFFC);
    xfer(2'd1, 2046, 30, 4, cyc, e);
    check("wrapl_r30", rf[30], 32'h0000_FFFF);
    check("wrapl_r31", rf[31], 32'h0000_FFFE);
    check("wrapl_r0",  rf[0],  32'h0000_FFFD);
    check("wrapl_r1",  rf[1],  32'h0000_FFFC);

    // len = 0 and reserved mode
    mw0 = n_mem_wr; rw0 = n_rf_wr;
    xfer(2'd0, 700, 0, 0, cyc, e);
    check("len0_lat", cyc, 1);
    check("len0_err", {31'd0, e}, 0);
    xfer(2'd3, 700, 0, 5, cyc, e);
    check("rsvd_lat", cyc, 1);
    check("rsvd_err", {31'd0, e}, 1);
    check("edge_nwr", (n_mem_wr - mw0) + (n_rf_wr - rw0), 0);

    // len above 32 is clamped
    mw0 = n_mem_wr;
    xfer(2'd0, 500, 0, 40, cyc, e);
    check("clamp_lat", cyc, 33);
    check("clamp_n",   n_mem_wr - mw0, 32);

    // start and input changes while busy are ignored
    mw0 = n_mem_wr;
    mode = 2'd0; mem_base = 11'd300; len = 6'd8; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cyc = 1;
    @(posedge clk); #1; cyc++;
    mode = 2'd2; mem_base = 11'd400; len = 6'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cyc++;
    while (!done && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("busy_lat",  cyc, 9);
    check("busy_n",    n_mem_wr - mw0, 8);
    check("busy_m307", {16'd0, sram[307]}, 32'h0000_FFF8);
    @(posedge clk); #1;

    // checksum on LOAD of 1, 2, 4
    tb_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tb_addr = 11'(600 + i); tb_data = 16'(1 << i);
      @(posedge clk); #1;
    end
    tb_we = 1'b0;
    xfer(2'd1, 600, 8, 3, cyc, e);
    check("csum_r10", rf[10], 32'h0000_0004);
`ifdef MEM_REG_DMA_CHECKSUM_EN
    check("csum_val", {16'd0, checksum}, 32'h0000_0007);
`else
    check("csum_val", {16'd0, checksum}, 32'h0000_0000);
`endif

    // async reset mid LOAD
    mode = 2'd1; mem_base = 11'd0; reg_base = 5'd0; len = 6'd32; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy", {31'd0, busy}, 0);
    check("mid_we",   {30'd0, mem_we, rf_we}, 0);
    check("mid_addr", {16'd0, mem_addr, rf_waddr}, 0);
    mw0 = n_mem_wr; rw0 = n_rf_wr;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("mid_nwr",  (n_mem_wr - mw0) + (n_rf_wr - rw0), 0);
    check("mid_idle", {30'd0, busy, done}, 0);

    check("no_strobe_in_done", n_bad, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_reg_dma.md
# mem_reg_dma

Parametrised block-transfer engine between the single-port 2K×16 SRAM and the 32×32 two-read/one-write register file. It moves a programmable-length block in one of three modes: pattern fill of SRAM, SRAM→register load, and register→SRAM store. A start/busy/done handshake replaces switch-stepped sequencing. It sits between the board top level, which drives the mode, base addresses and start, and the two storage blocks.

## Interface
- `ADDR_W`, 11, SRAM address width
- `DATA_W`, 16, SRAM data width
- `REG_AW`, 5, register-file address width
- `REG_W`, 32, register width (must be ≥ `DATA_W`)
- `clk` in 1: single clock; all logic is on its rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `start` in 1: request a transfer; sampled only in IDLE
- `mode` in 2: 0 FILL, 1 LOAD, 2 STORE, 3 reserved
- `mem_base` in `ADDR_W`: first SRAM address
- `reg_base` in `REG_AW`: first register index
- `len` in `REG_AW`+1: word count, 0..2^`REG_AW`
- `busy` out 1: high from the cycle after an accepted start until `done`
- `done` out 1: one-cycle completion pulse
- `err` out 1: one-cycle pulse coincident with `done` for mode 3
- `mem_addr` out `ADDR_W`; `mem_we` out 1 (1 = write); `mem_wdata` out `DATA_W`
- `mem_rdata` in `DATA_W`: synchronous read; valid the cycle after `mem_addr`
- `rf_raddr` out `REG_AW`; `rf_rdata` in `REG_W`: combinational read
- `rf_we` out 1; `rf_waddr` out `REG_AW`; `rf_wdata` out `REG_W`
- `checksum` out `DATA_W`: see Configuration

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `start`=1 with `len`=0 or `mode`=3 → DONE.
  - Otherwise latch `mode`, `mem_base`, `reg_base` and `len`; clear index `i`; → RUN.
  - `start` is ignored in every other state.
- **RUN**, one word per cycle, for `i` = 0..`len`-1:
  - FILL: `mem_addr`=`mem_base`+`i`, `mem_we`=1, `mem_wdata`=~`i` (index zero-extended to `DATA_W`, then inverted).
  - STORE: `rf_raddr`=`reg_base`+`i`, `mem_addr`=`mem_base`+`i`, `mem_we`=1, `mem_wdata`=`rf_rdata`[`DATA_W`-1:0].
  - LOAD: `mem_addr`=`mem_base`+`i`, `mem_we`=0. For `i`≥1, `rf_we`=1, `rf_waddr`=`reg_base`+`i`-1, `rf_wdata`=zero-extended `mem_rdata`.
  - Last index: LOAD → DRAIN; all other modes → DONE.
- **DRAIN** (LOAD only): writes the final word (`rf_waddr`=`reg_base`+`len`-1); → DONE.
- **DONE**: `done`=1, `err`=1 if the latched mode is 3; → IDLE.
- Arithmetic:
  - SRAM addresses wrap modulo 2^`ADDR_W`.
  - Register indices wrap modulo 2^`REG_AW`.
  - `len` > 2^`REG_AW` is clamped to 2^`REG_AW`.
- `mem_we` and `rf_we` are 0 outside RUN/DRAIN.
- `busy` and `done` are never high in the same cycle.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `mem_we` and `rf_we` = 0; all address, data and `checksum` outputs = 0.
- Latency from the `start` sample edge to the `done` pulse:
  - FILL/STORE: `len`+1 cycles.
  - LOAD: `len`+2 cycles.
  - `len`=0 or mode 3: 1 cycle.
- Back-to-back: a `start` presented in the cycle `done` is high is not accepted. The earliest acceptance is the following (IDLE) cycle.
- Reset asserted mid-transfer: all strobes drop asynchronously, no further writes occur, and the partial block is left as is.
- Changing `mode`, base addresses or `len` while `busy` has no effect.

## Configuration
- `MEM_REG_DMA_CHECKSUM_EN` defined:
  - `checksum` is cleared on an accepted start.
  - It XOR-accumulates every word written, in each mode: the low `DATA_W` bits of `rf_wdata` in LOAD, `mem_wdata` in FILL/STORE.
  - It holds its value after `done`.
- Undefined: `checksum` is tied to 0 and no accumulator register exists.

## Structure
- Package `mem_reg_dma_pkg`:
  - mode enum (`MODE_FILL`, `MODE_LOAD`, `MODE_STORE`, `MODE_RSVD`)
  - FSM state enum
  - default width constants
- Sub-module `mem_reg_dma_ctr`: index counter and base+offset address generators with wrap. The FSM and datapath remain in the top module.

## Test plan
All scenarios use default parameters.
- FILL with `mem_base`=0 and `len`=32 → SRAM[0..31] = 0xFFFF..0xFFE0; `done` at cycle 33; `err`=0.
- LOAD with `mem_base`=64, `reg_base`=0, `len`=32, after a FILL at 64 → reg[k] = 0x0000_FFFF-k; `done` at cycle 34; no `rf_we` in the DONE cycle.
- STORE with `reg_base`=16, `mem_base`=145, `len`=4 → SRAM[145..148] equal the low halves of reg[16..19].
- Wrap: FILL with `mem_base`=2046, `len`=4 → writes 2046, 2047, 0, 1. LOAD with `reg_base`=30, `len`=4 → registers 30, 31, 0, 1.
- Edge cases:
  - `len`=0 → `done` one cycle later, no strobes.
  - mode 3 → `done` and `err` together.
  - `start` pulsed while `busy` → ignored.
- `rst_n` dropped at cycle 10 of a 32-word LOAD → outputs zero immediately, no further writes. With `MEM_REG_DMA_CHECKSUM_EN`, a LOAD of 0x0001, 0x0002, 0x0004 gives `checksum`=0x0007.
